// File: rtl/riscv_instr_byte_writer.sv
// RV32I R/I/S field packer that streams each 32-bit word little-endian, one byte
// per beat, into byte-wide instruction memory at an auto-incrementing address.
module riscv_instr_byte_writer #(
  parameter int          ADDR_WIDTH = 16,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  restart,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_format,
  input  logic [6:0]            in_opcode,
  input  logic [4:0]            in_rd,
  input  logic [2:0]            in_funct3,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [6:0]            in_funct7,
  input  logic [11:0]           in_imm,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic [15:0]           instr_count,
  output logic                  err_format
);

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] wptr;
  logic [1:0]            byte_idx;
  logic [31:0]           word;
  logic [31:0]           packed_word;
  logic                  xfer;

  assign in_ready = (state == IDLE) & ~rst & ~restart;
  assign xfer     = in_valid & in_ready;

  always_comb begin
    packed_word = '0;
    case (in_format)
      2'd0:    packed_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      2'd1:    packed_word = {in_imm, in_rs1, in_funct3, in_rd, in_opcode};
      default: packed_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
    endcase
  end

  // Memory side depends on registered state only, so it is glitch-free w.r.t. in_*.
  assign mem_we    = (state == WRITE);
  assign mem_addr  = wptr + ADDR_WIDTH'(byte_idx);
  assign mem_wdata = word[{byte_idx, 3'b000} +: 8];
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wptr        <= BASE;
      byte_idx    <= 2'd0;
      word        <= '0;
      instr_count <= '0;
      err_format  <= 1'b0;
    end else begin
      err_format <= xfer & (in_format == 2'd3);
      if (restart) begin
        // Abandons the instruction even on its final beat: no count, pointer rewinds.
        state    <= IDLE;
        byte_idx <= 2'd0;
        wptr     <= BASE;
      end else begin
        case (state)
          IDLE: begin
            if (xfer && in_format != 2'd3) begin
              word     <= packed_word;
              byte_idx <= 2'd0;
              state    <= WRITE;
            end
          end
          WRITE: begin
            if (mem_ready) begin
              byte_idx <= byte_idx + 2'd1;
              if (byte_idx == 2'd3) begin
                wptr        <= wptr + ADDR_WIDTH'(4);
                instr_count <= instr_count + 16'd1;
                state       <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_riscv_instr_byte_writer.sv
// Directed bench: two instances (default and a 4-bit wrapping address space),
// byte writes captured into bench-side memories and checked against hand-coded words.
module tb_riscv_instr_byte_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        restart = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_format = '0;
  logic [6:0]  in_opcode = '0;
  logic [4:0]  in_rd = '0;
  logic [2:0]  in_funct3 = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [11:0] in_imm = '0;
  logic        mem_ready = 1'b1;

  logic        in_ready0, mem_we0, busy0, err0;
  logic [15:0] addr0, count0;
  logic [7:0]  wdata0;
  logic        in_ready1, mem_we1, busy1, err1;
  logic [3:0]  addr1;
  logic [15:0] count1;
  logic [7:0]  wdata1;

  logic [7:0]  mem0 [256];
  logic [7:0]  mem1 [16];
  int          wr_cnt0 = 0;
  int          compared = 0;
  int          mismatched = 0;

  always #5 clk = ~clk;

  riscv_instr_byte_writer #(.ADDR_WIDTH(16), .BASE_ADDR(0)) dut0 (
    .clk(clk), .rst(rst), .restart(restart), .in_valid(in_valid), .in_ready(in_ready0),
    .in_format(in_format), .in_opcode(in_opcode), .in_rd(in_rd), .in_funct3(in_funct3),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct7(in_funct7), .in_imm(in_imm),
    .mem_we(mem_we0), .mem_addr(addr0), .mem_wdata(wdata0), .mem_ready(mem_ready),
    .busy(busy0), .instr_count(count0), .err_format(err0));

  riscv_instr_byte_writer #(.ADDR_WIDTH(4), .BASE_ADDR(12)) dut1 (
    .clk(clk), .rst(rst), .restart(restart), .in_valid(in_valid), .in_ready(in_ready1),
    .in_format(in_format), .in_opcode(in_opcode), .in_rd(in_rd), .in_funct3(in_funct3),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct7(in_funct7), .in_imm(in_imm),
    .mem_we(mem_we1), .mem_addr(addr1), .mem_wdata(wdata1), .mem_ready(mem_ready),
    .busy(busy1), .instr_count(count1), .err_format(err1));

  always @(posedge clk) begin
    if (mem_we0 && mem_ready) begin
      mem0[addr0[7:0]] <= wdata0;
      wr_cnt0 <= wr_cnt0 + 1;
    end
    if (mem_we1 && mem_ready) mem1[addr1] <= wdata1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word0(input int a);
    return {mem0[a+3], mem0[a+2], mem0[a+1], mem0[a]};
  endfunction

  function automatic logic [31:0] word1(input int a);
    return {mem1[(a+3)%16], mem1[(a+2)%16], mem1[(a+1)%16], mem1[a%16]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction for a single accept cycle; returns #1 after the transfer edge.
  task automatic accept(input logic [1:0] f, input logic [6:0] op, input logic [4:0] rd,
                        input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [6:0] f7, input logic [11:0] imm);
    int n = 0;
    while (!in_ready0 && n < 40) begin step(); n++; end
    check("ready_timeout", {31'd0, in_ready0}, 32'd1);
    in_format = f; in_opcode = op; in_rd = rd; in_funct3 = f3;
    in_rs1 = rs1; in_rs2 = rs2; in_funct7 = f7; in_imm = imm;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy0 || busy1) && n < 40) begin step(); n++; end
    check("idle_timeout", {31'd0, busy0 | busy1}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem0[i] = 8'h00;
    for (int i = 0; i < 16; i++) mem1[i] = 8'h00;

    // Reset state
    #2;
    check("rst_in_ready", {31'd0, in_ready0}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we0}, 32'd0);
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_count", {16'd0, count0}, 32'd0);
    check("rst_err", {31'd0, err0}, 32'd0);
    step();
    rst = 1'b0;
    step();
    check("idle_in_ready", {31'd0, in_ready0}, 32'd1);

    // 1: addi x1,x0,5
    accept(2'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 12'd5);
    check("t1_first_addr", {16'd0, addr0}, 32'd0);
    check("t1_first_byte", {24'd0, wdata0}, 32'h93);
    check("t1_in_ready_busy", {31'd0, in_ready0}, 32'd0);
    wait_idle();
    check("t1_word", word0(0), 32'h00500093);
    check("t1_count", {16'd0, count0}, 32'd1);

    // 2: add x3,x1,x2
    accept(2'd0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 12'd0);
    check("t2_first_addr", {16'd0, addr0}, 32'd4);
    wait_idle();
    check("t2_word", word0(4), 32'h002081B3);
    check("t2_count", {16'd0, count0}, 32'd2);

    // 3: sw x2,8(x1) with a 3-cycle stall on byte 1
    accept(2'd2, 7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 12'd8);
    check("t3_b0_addr", {16'd0, addr0}, 32'd8);
    step();
    mem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("t3_stall_we", {31'd0, mem_we0}, 32'd1);
      check("t3_stall_addr", {16'd0, addr0}, 32'd9);
      check("t3_stall_data", {24'd0, wdata0}, 32'hA4);
      step();
    end
    check("t3_after_stall_addr", {16'd0, addr0}, 32'd9);
    mem_ready = 1'b1;
    wait_idle();
    check("t3_word", word0(8), 32'h0020A423);
    check("t3_count", {16'd0, count0}, 32'd3);
    check("t3_write_beats", wr_cnt0, 32'd12);

    // 4: illegal format is dropped with a single-cycle error pulse
    accept(2'd3, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 12'd5);
    check("t4_err_hi", {31'd0, err0}, 32'd1);
    check("t4_no_we", {31'd0, mem_we0}, 32'd0);
    check("t4_busy", {31'd0, busy0}, 32'd0);
    step();
    check("t4_err_lo", {31'd0, err0}, 32'd0);
    check("t4_count", {16'd0, count0}, 32'd3);
    check("t4_no_writes", wr_cnt0, 32'd12);
    accept(2'd1, 7'h13, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 12'd1);
    check("t4_next_addr", {16'd0, addr0}, 32'd12);
    wait_idle();
    check("t4_next_word", word0(12), 32'h00100293);
    check("t4_next_count", {16'd0, count0}, 32'd4);

    // 5: async reset after byte 1 is written
    accept(2'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 12'd5);
    step();
    check("t5_mid_we", {31'd0, mem_we0}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_we", {31'd0, mem_we0}, 32'd0);
    check("t5_rst_busy", {31'd0, busy0}, 32'd0);
    check("t5_rst_count", {16'd0, count0}, 32'd0);
    #3;
    rst = 1'b0;
    step();
    accept(2'd0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 12'd0);
    check("t5_base_addr", {16'd0, addr0}, 32'd0);
    wait_idle();
    check("t5_word", word0(0), 32'h002081B3);
    check("t5_count", {16'd0, count0}, 32'd1);

    // 6: 4-bit address space based at 12 wraps; restart beats the last beat
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) mem1[i] = 8'h00;
    step();
    accept(2'd1, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 12'd5);
    check("t6_first_addr", {28'd0, addr1}, 32'd12);
    wait_idle();
    accept(2'd0, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 12'd0);
    check("t6_wrap_addr", {28'd0, addr1}, 32'd0);
    wait_idle();
    check("t6_word_a", word1(12), 32'h00500093);
    check("t6_word_b", word1(0), 32'h002081B3);
    check("t6_count", {16'd0, count1}, 32'd2);
    accept(2'd2, 7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 12'd8);
    step();
    step();
    step();
    check("t6_last_beat_addr", {28'd0, addr1}, 32'd7);
    check("t6_last_beat_data", {24'd0, wdata1}, 32'h00);
    restart = 1'b1;
    step();
    restart = 1'b0;
    check("t6_restart_busy", {31'd0, busy1}, 32'd0);
    check("t6_restart_count", {16'd0, count1}, 32'd2);
    accept(2'd1, 7'h13, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 12'd1);
    check("t6_restart_addr", {28'd0, addr1}, 32'd12);
    wait_idle();
    check("t6_restart_word", word1(12), 32'h00100293);
    check("t6_final_count", {16'd0, count1}, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
